// File: rtl/ysyx_24080006_csr_ctrl_if.sv
// Bundle between the EXU pipeline, the CSR control sequencer and the CSR register file.
// slave: the sequencer's view; master: the surrounding pipeline/CSR-file environment.
interface ysyx_24080006_csr_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic            in_is_ecall;
    logic            in_is_mret;
    logic [11:0]     in_csr_addr;
    logic [4:0]      in_rs1_idx;
    logic [XLEN-1:0] in_rs1_data;
    logic [4:0]      in_rd_idx;
    logic [31:0]     in_pc;

    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;
    logic            trap_ecall;
    logic            trap_mret;
    logic [31:0]     trap_pc;

    logic            out_valid;
    logic            out_ready;
    logic            out_rd_we;
    logic [4:0]      out_rd_idx;
    logic [XLEN-1:0] out_rd_wdata;
    logic            out_redirect;
    logic [31:0]     out_redirect_pc;
    logic            out_illegal;
    logic            instret;

    modport slave (
        input  in_valid, in_funct3, in_is_ecall, in_is_mret, in_csr_addr,
               in_rs1_idx, in_rs1_data, in_rd_idx, in_pc, csr_rdata, out_ready,
        output in_ready, csr_addr, csr_we, csr_wdata, trap_ecall, trap_mret, trap_pc,
               out_valid, out_rd_we, out_rd_idx, out_rd_wdata, out_redirect,
               out_redirect_pc, out_illegal, instret
    );

    modport master (
        output in_valid, in_funct3, in_is_ecall, in_is_mret, in_csr_addr,
               in_rs1_idx, in_rs1_data, in_rd_idx, in_pc, csr_rdata, out_ready,
        input  in_ready, csr_addr, csr_we, csr_wdata, trap_ecall, trap_mret, trap_pc,
               out_valid, out_rd_we, out_rd_idx, out_rd_wdata, out_redirect,
               out_redirect_pc, out_illegal, instret
    );
endinterface

// File: rtl/ysyx_24080006_csr_ctrl.sv
// CSR access sequencer: read then optional read-modify-write for Zicsr ops,
// and ECALL/MRET trap entry/exit with PC redirect.
module ysyx_24080006_csr_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter logic [11:0] MTVEC_ADDR = 12'h305,
    parameter logic [11:0] MEPC_ADDR  = 12'h341
) (
    input logic                     clock,
    input logic                     reset,
    ysyx_24080006_csr_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_TRAP,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            ecall_q, ecall_d;
    logic [11:0]     addr_q, addr_d;
    logic [4:0]      rs1_idx_q, rs1_idx_d;
    logic [4:0]      rd_idx_q, rd_idx_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [31:0]     pc_q, pc_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            illegal_q, illegal_d;
    logic            rd_we_q, rd_we_d;
    logic            redirect_q, redirect_d;
    logic [31:0]     redirect_pc_q, redirect_pc_d;

    logic            is_csr_op, write_needed, addr_known, illegal;
    logic [XLEN-1:0] src, new_val;

    always_comb begin
        is_csr_op    = funct3_q[1:0] != 2'b00;
        // Set/clear with rs1=x0 (or zimm=0) must not touch the CSR at all.
        write_needed = (funct3_q[1:0] == 2'b01) || (is_csr_op && rs1_idx_q != '0);
        addr_known   = addr_q inside {12'h300, 12'h305, 12'h341, 12'h342,
                                      12'hB02, 12'hB82, 12'hF11, 12'hF12};
        illegal      = !is_csr_op || !addr_known || (write_needed && addr_q[11:10] == 2'b11);
        src          = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;
        case (funct3_q[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = bus.csr_rdata | src;
            2'b11:   new_val = bus.csr_rdata & ~src;
            default: new_val = bus.csr_rdata;
        endcase
    end

    always_comb begin
        bus.csr_addr = '0;
        case (state_q)
            S_READ, S_WRITE: bus.csr_addr = addr_q;
            S_TRAP:          bus.csr_addr = ecall_q ? MTVEC_ADDR : MEPC_ADDR;
            default:         bus.csr_addr = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            funct3_q      <= '0;
            ecall_q       <= 1'b0;
            addr_q        <= '0;
            rs1_idx_q     <= '0;
            rd_idx_q      <= '0;
            rs1_data_q    <= '0;
            pc_q          <= '0;
            old_q         <= '0;
            wdata_q       <= '0;
            illegal_q     <= 1'b0;
            rd_we_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            funct3_q      <= funct3_d;
            ecall_q       <= ecall_d;
            addr_q        <= addr_d;
            rs1_idx_q     <= rs1_idx_d;
            rd_idx_q      <= rd_idx_d;
            rs1_data_q    <= rs1_data_d;
            pc_q          <= pc_d;
            old_q         <= old_d;
            wdata_q       <= wdata_d;
            illegal_q     <= illegal_d;
            rd_we_q       <= rd_we_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        funct3_d            = funct3_q;
        ecall_d             = ecall_q;
        addr_d              = addr_q;
        rs1_idx_d           = rs1_idx_q;
        rd_idx_d            = rd_idx_q;
        rs1_data_d          = rs1_data_q;
        pc_d                = pc_q;
        old_d               = old_q;
        wdata_d             = wdata_q;
        illegal_d           = illegal_q;
        rd_we_d             = rd_we_q;
        redirect_d          = redirect_q;
        redirect_pc_d       = redirect_pc_q;
        bus.in_ready        = 1'b0;
        bus.csr_we          = 1'b0;
        bus.csr_wdata       = '0;
        bus.trap_ecall      = 1'b0;
        bus.trap_mret       = 1'b0;
        bus.trap_pc         = '0;
        bus.out_valid       = 1'b0;
        bus.out_rd_we       = 1'b0;
        bus.out_rd_idx      = '0;
        bus.out_rd_wdata    = '0;
        bus.out_redirect    = 1'b0;
        bus.out_redirect_pc = '0;
        bus.out_illegal     = 1'b0;
        bus.instret         = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    funct3_d   = bus.in_funct3;
                    ecall_d    = bus.in_is_ecall;
                    addr_d     = bus.in_csr_addr;
                    rs1_idx_d  = bus.in_rs1_idx;
                    rs1_data_d = bus.in_rs1_data;
                    rd_idx_d   = bus.in_rd_idx;
                    pc_d       = bus.in_pc;
                    state_d    = (bus.in_is_ecall || bus.in_is_mret) ? S_TRAP : S_READ;
                end
            end
            S_READ: begin
                old_d         = bus.csr_rdata;
                wdata_d       = new_val;
                illegal_d     = illegal;
                rd_we_d       = !illegal && rd_idx_q != '0;
                redirect_d    = 1'b0;
                redirect_pc_d = '0;
                state_d       = (write_needed && !illegal) ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                bus.csr_we    = 1'b1;
                bus.csr_wdata = wdata_q;
                state_d       = S_RESP;
            end
            S_TRAP: begin
                // Target is sampled before the trap pulse lets the file update its state.
                bus.trap_ecall = ecall_q;
                bus.trap_mret  = !ecall_q;
                bus.trap_pc    = ecall_q ? pc_q : '0;
                old_d          = '0;
                illegal_d      = 1'b0;
                rd_we_d        = 1'b0;
                redirect_d     = 1'b1;
                redirect_pc_d  = {bus.csr_rdata[31:2], 2'b00};
                state_d        = S_RESP;
            end
            S_RESP: begin
                bus.out_valid       = 1'b1;
                bus.out_rd_we       = rd_we_q;
                bus.out_rd_idx      = rd_idx_q;
                bus.out_rd_wdata    = old_q;
                bus.out_redirect    = redirect_q;
                bus.out_redirect_pc = redirect_pc_q;
                bus.out_illegal     = illegal_q;
                bus.instret         = bus.out_ready && !illegal_q;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
